// File: rtl/dual_scan_pkg.sv
// dual_scan_pkg: shared FSM states, unit ids and default buffer depth for dual_scan_ctrl
package dual_scan_pkg;
  typedef enum logic [2:0] {IDLE, START, SCAN, XFER, SWAP, HALT} state_e;
  localparam logic UNIT_A = 1'b0;
  localparam logic UNIT_B = 1'b1;
  localparam int CAPACITY_DEF = 100;
endpackage

// File: rtl/dual_scan_ctrl_scan_unit_if.sv
// scan_unit_if: per-scanner front end (input history, edge detect, decrement strobe, registered pulses)
// Ports: start_req_i/standby_req_i -> start_scan_o/standby_o one cycle later;
//        ready_transfer_i, ready_second_i, start_second_i, data_count_i from the scanner;
//        full_o, empty_o, rs_rise_o, ss_rise_o, dec_o status strobes to the controller.
module scan_unit_if
  import dual_scan_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_req_i,
  input  logic             standby_req_i,
  input  logic             ready_transfer_i,
  input  logic             ready_second_i,
  input  logic             start_second_i,
  input  logic [CNT_W-1:0] data_count_i,
  output logic             start_scan_o,
  output logic             standby_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             rs_rise_o,
  output logic             ss_rise_o,
  output logic             dec_o
);
  logic rs_q, ss_q, start_q, standby_q;
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rs_q <= 1'b0;
      ss_q <= 1'b0;
      cnt_q <= '0;
      start_q <= 1'b0;
      standby_q <= 1'b0;
    end else begin
      rs_q <= ready_second_i;
      ss_q <= start_second_i;
      cnt_q <= data_count_i;
      start_q <= start_req_i;
      standby_q <= standby_req_i;
    end
  assign start_scan_o = start_q;
  assign standby_o = standby_q;
  assign full_o = ready_transfer_i && data_count_i == CNT_W'(CAPACITY);
  assign empty_o = data_count_i == '0;
  assign rs_rise_o = ready_second_i && !rs_q;
  assign ss_rise_o = start_second_i && !ss_q;
  // only an exact step of -1 counts as a word; a zero history cannot wrap into a false hit
  assign dec_o = cnt_q != '0 && data_count_i == cnt_q - CNT_W'(1);
endmodule

// File: rtl/dual_scan_ctrl.sv
// dual_scan_ctrl: ping-pong host controller for two scanner units A and B
// Ports: enable/stop host requests; a_*/b_* scanner handshakes (start_scan, transfer, flush,
//        standby out; ready_to_transfer, ready_second, start_second, data_count in);
//        rx_valid/rx_unit per received word, frames_done counter, busy, timeout_err.
// Build option: DUAL_SCAN_TIMEOUT_EN adds the XFER watchdog driving timeout_err.
module dual_scan_ctrl
  import dual_scan_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int CNT_W = 8,
  parameter int XFER_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             stop,
  output logic             a_start_scan,
  output logic             b_start_scan,
  output logic             a_transfer,
  output logic             b_transfer,
  output logic             a_flush,
  output logic             b_flush,
  output logic             a_standby,
  output logic             b_standby,
  input  logic             a_ready_to_transfer,
  input  logic             b_ready_to_transfer,
  input  logic             a_ready_second,
  input  logic             b_ready_second,
  input  logic             a_start_second,
  input  logic             b_start_second,
  input  logic [CNT_W-1:0] a_data_count,
  input  logic [CNT_W-1:0] b_data_count,
  output logic             rx_valid,
  output logic             rx_unit,
  output logic [15:0]      frames_done,
  output logic             busy,
  output logic             timeout_err
);
  state_e state_q, state_d;
  logic cur_q, other_started_q, sb_done_q, rx_valid_q, rx_unit_q, to;
  logic [15:0] frames_q;
  logic [1:0] start_req, sb_req, start_p, sb_p, full, empty, rs_rise, ss_rise, dec, xfer, flush;

  scan_unit_if #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst(rst), .start_req_i(start_req[UNIT_A]), .standby_req_i(sb_req[UNIT_A]),
    .ready_transfer_i(a_ready_to_transfer), .ready_second_i(a_ready_second),
    .start_second_i(a_start_second), .data_count_i(a_data_count),
    .start_scan_o(start_p[UNIT_A]), .standby_o(sb_p[UNIT_A]), .full_o(full[UNIT_A]),
    .empty_o(empty[UNIT_A]), .rs_rise_o(rs_rise[UNIT_A]), .ss_rise_o(ss_rise[UNIT_A]),
    .dec_o(dec[UNIT_A])
  );

  scan_unit_if #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst(rst), .start_req_i(start_req[UNIT_B]), .standby_req_i(sb_req[UNIT_B]),
    .ready_transfer_i(b_ready_to_transfer), .ready_second_i(b_ready_second),
    .start_second_i(b_start_second), .data_count_i(b_data_count),
    .start_scan_o(start_p[UNIT_B]), .standby_o(sb_p[UNIT_B]), .full_o(full[UNIT_B]),
    .empty_o(empty[UNIT_B]), .rs_rise_o(rs_rise[UNIT_B]), .ss_rise_o(ss_rise[UNIT_B]),
    .dec_o(dec[UNIT_B])
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = enable && !stop ? START : IDLE;
      START: state_d = stop ? HALT : SCAN;
      SCAN:  state_d = stop ? HALT : full[cur_q] ? XFER : SCAN;
      XFER:  state_d = empty[cur_q] ? SWAP : to ? HALT : XFER;
      SWAP:  state_d = stop || !enable ? HALT : other_started_q ? SCAN : START;
      HALT:  state_d = &empty ? IDLE : HALT;
      default: state_d = IDLE;
    endcase
  end

  // pre-wake requests target the idle unit and are each allowed once per frame
  always_comb begin
    xfer = '0;
    start_req = '0;
    sb_req = '0;
    xfer[cur_q] = state_q == XFER;
    start_req[cur_q] = state_q == START && !stop;
    start_req[~cur_q] = state_q == SCAN && ss_rise[cur_q] && !other_started_q;
    sb_req[~cur_q] = state_q == SCAN && rs_rise[cur_q] && !sb_done_q;
    flush = {2{state_q == HALT}} & ~empty;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_q <= UNIT_A;
      other_started_q <= 1'b0;
      sb_done_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_unit_q <= 1'b0;
      frames_q <= '0;
    end else begin
      rx_valid_q <= state_q == XFER && dec[cur_q];
      if (state_q == XFER && dec[cur_q]) rx_unit_q <= cur_q;
      if (state_q == XFER && empty[cur_q]) frames_q <= frames_q + 16'd1;
      if (state_q == SCAN && ss_rise[cur_q]) other_started_q <= 1'b1;
      if (state_q == SCAN && rs_rise[cur_q]) sb_done_q <= 1'b1;
      if (state_q == SWAP) begin
        cur_q <= ~cur_q;
        sb_done_q <= 1'b0;
        if (state_d == SCAN) other_started_q <= 1'b0;
      end
      if (state_q == HALT && state_d == IDLE) other_started_q <= 1'b0;
    end

`ifdef DUAL_SCAN_TIMEOUT_EN
  logic [15:0] wd_q;
  logic err_q;
  // fires on the XFER_TIMEOUT-th consecutive XFER cycle without a decrement
  assign to = state_q == XFER && !dec[cur_q] && !empty[cur_q] && wd_q == 16'(XFER_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= state_q == XFER && !dec[cur_q] ? wd_q + 16'd1 : '0;
      if (to) err_q <= 1'b1;
    end
  assign timeout_err = err_q;
`else
  logic unused_to;
  assign unused_to = XFER_TIMEOUT[0];
  assign to = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign a_start_scan = start_p[UNIT_A];
  assign b_start_scan = start_p[UNIT_B];
  assign a_standby = sb_p[UNIT_A];
  assign b_standby = sb_p[UNIT_B];
  assign a_transfer = xfer[UNIT_A];
  assign b_transfer = xfer[UNIT_B];
  assign a_flush = flush[UNIT_A];
  assign b_flush = flush[UNIT_B];
  assign rx_valid = rx_valid_q;
  assign rx_unit = rx_unit_q;
  assign frames_done = frames_q;
  assign busy = state_q != IDLE;
endmodule
